// File: rtl/io_pad_bidir_bridge_pkg.sv
// -----------------------------------------------------------------------------
// io_pad_pkg
// Shared types and default parameters for the pad-ring bidirectional bridge.
//   pad_state_t     : output-enable turnaround FSM encoding
//   FILTER_LEN_DEF  : default glitch-filter length (samples)
//   TURN_CYC_DEF    : default high-Z guard cycles on each enable edge
//   CNT_W_DEF       : default width of the filter / turnaround counters
// -----------------------------------------------------------------------------
package io_pad_pkg;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    ON_WAIT  = 2'd1,
    DRIVE    = 2'd2,
    OFF_WAIT = 2'd3
  } pad_state_t;

  localparam int FILTER_LEN_DEF = 2;
  localparam int TURN_CYC_DEF   = 1;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/io_pad_bidir_bridge_if.sv
// -----------------------------------------------------------------------------
// io_pad_bidir_bridge_if
// Groups the fabric-side (IO BEL) and pad-side signals of the bridge.
//   I_top, T_top   : drive data / output enable from the IO BEL
//   O_top          : filtered pad input back to the IO BEL
//   PAD_O, PAD_OE  : pad buffer data / enable
//   PAD_I          : pad buffer input
//   TURN_BUSY      : turnaround guard in progress
//   PAD_MISMATCH   : read-back disagrees with driven data (IO_PAD_LOOPBACK_EN)
// Modports: master = fabric + pad buffer side, slave = the bridge itself.
// Optional feature macro: IO_PAD_LOOPBACK_EN
// -----------------------------------------------------------------------------
interface io_pad_bidir_bridge_if;
  import io_pad_pkg::*;

  logic I_top;
  logic T_top;
  logic O_top;
  logic PAD_O;
  logic PAD_OE;
  logic PAD_I;
  logic TURN_BUSY;
`ifdef IO_PAD_LOOPBACK_EN
  logic PAD_MISMATCH;

  modport master (
    output I_top, T_top, PAD_I,
    input  O_top, PAD_O, PAD_OE, TURN_BUSY, PAD_MISMATCH
  );

  modport slave (
    input  I_top, T_top, PAD_I,
    output O_top, PAD_O, PAD_OE, TURN_BUSY, PAD_MISMATCH
  );
`else
  modport master (
    output I_top, T_top, PAD_I,
    input  O_top, PAD_O, PAD_OE, TURN_BUSY
  );

  modport slave (
    input  I_top, T_top, PAD_I,
    output O_top, PAD_O, PAD_OE, TURN_BUSY
  );
`endif

endinterface

// File: rtl/io_pad_glitch_filter.sv
// -----------------------------------------------------------------------------
// io_pad_glitch_filter
// Two-flop synchroniser followed by a persistence filter: q only follows the
// synchronised input after FILTER_LEN consecutive differing samples.
//   UserCLK : clock
//   Reset   : asynchronous, active-high
//   en      : filter update enable; when low, q and the counter hold while the
//             synchroniser keeps sampling
//   d       : raw pad input
//   q       : filtered output
// -----------------------------------------------------------------------------
module io_pad_glitch_filter
  import io_pad_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic UserCLK,
  input  logic Reset,
  input  logic en,
  input  logic d,
  output logic q
);

  // fcnt+1 == FILTER_LEN is tested as fcnt == FILTER_LEN-1 to stay in CNT_W bits
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             s1_reg;
  logic             s2_reg;
  logic             q_reg;
  logic [CNT_W-1:0] fcnt_reg;

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      q_reg    <= 1'b0;
      fcnt_reg <= '0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
      if (en) begin
        if (s2_reg == q_reg) begin
          fcnt_reg <= '0;
        end else if (fcnt_reg == FILTER_LAST) begin
          q_reg    <= s2_reg;
          fcnt_reg <= '0;
        end else begin
          fcnt_reg <= fcnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/io_pad_bidir_bridge.sv
// -----------------------------------------------------------------------------
// io_pad_bidir_bridge
// Pad-side counterpart of the fabric bidirectional IO BEL.
//   UserCLK : fabric user clock
//   Reset   : asynchronous, active-high; drops PAD_OE without a clock edge
//   bus     : io_pad_bidir_bridge_if.slave
//             I_top/T_top in, O_top out (IO BEL side)
//             PAD_O/PAD_OE out, PAD_I in (pad buffer side)
//             TURN_BUSY out, high while in ON_WAIT / OFF_WAIT
// Output path: PAD_O registers I_top; PAD_OE is sequenced by a turnaround FSM
// that inserts TURN_CYC high-Z guard cycles on both enable edges.
// Input path: synchronised and glitch-filtered pad input, frozen while driving.
// Optional feature macro: IO_PAD_LOOPBACK_EN -- filter also runs while driving
// and PAD_MISMATCH flags read-back disagreeing with driven data.
// -----------------------------------------------------------------------------
module io_pad_bidir_bridge
  import io_pad_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int TURN_CYC   = TURN_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  UserCLK,
  input  logic                  Reset,
  io_pad_bidir_bridge_if.slave  bus
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  pad_state_t       state_reg;
  logic [CNT_W-1:0] tcnt_reg;
  logic             pad_o_reg;
  logic             pad_oe_reg;
  logic             turn_busy_reg;
  logic             filter_en;
  logic             o_top_filt;

  // Enable FSM. PAD_OE and TURN_BUSY are assigned alongside the state change
  // so they always reflect the state being entered.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_reg     <= HIZ;
      tcnt_reg      <= '0;
      pad_o_reg     <= 1'b0;
      pad_oe_reg    <= 1'b0;
      turn_busy_reg <= 1'b0;
    end else begin
      pad_o_reg <= bus.I_top;
      case (state_reg)
        HIZ: begin
          if (bus.T_top) begin
            if (TURN_CYC == 0) begin
              state_reg     <= DRIVE;
              pad_oe_reg    <= 1'b1;
              turn_busy_reg <= 1'b0;
            end else begin
              state_reg     <= ON_WAIT;
              tcnt_reg      <= TURN_LOAD;
              turn_busy_reg <= 1'b1;
            end
          end
        end
        ON_WAIT: begin
          if (!bus.T_top) begin
            state_reg     <= HIZ;
            turn_busy_reg <= 1'b0;
          end else if (tcnt_reg == CNT_ONE) begin
            state_reg     <= DRIVE;
            pad_oe_reg    <= 1'b1;
            turn_busy_reg <= 1'b0;
          end else begin
            tcnt_reg <= tcnt_reg - CNT_ONE;
          end
        end
        DRIVE: begin
          if (!bus.T_top) begin
            pad_oe_reg <= 1'b0;
            if (TURN_CYC == 0) begin
              state_reg     <= HIZ;
              turn_busy_reg <= 1'b0;
            end else begin
              state_reg     <= OFF_WAIT;
              tcnt_reg      <= TURN_LOAD;
              turn_busy_reg <= 1'b1;
            end
          end
        end
        OFF_WAIT: begin
          // T_top is ignored here: a re-request always sits out the full guard
          if (tcnt_reg == CNT_ONE) begin
            state_reg     <= HIZ;
            turn_busy_reg <= 1'b0;
          end else begin
            tcnt_reg <= tcnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg     <= HIZ;
          pad_oe_reg    <= 1'b0;
          turn_busy_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef IO_PAD_LOOPBACK_EN
  // Mismatch is only trusted once the drive has lasted long enough for the
  // driven level to pass through the synchroniser and filter.
  localparam logic [CNT_W:0] HOLD_LAST = (CNT_W + 1)'(FILTER_LEN + 2);
  localparam logic [CNT_W:0] HOLD_ONE  = (CNT_W + 1)'(1);

  logic [CNT_W:0] drive_cnt_reg;
  logic           mismatch_reg;

  assign filter_en = 1'b1;

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      drive_cnt_reg <= '0;
      mismatch_reg  <= 1'b0;
    end else begin
      if (state_reg != DRIVE) begin
        drive_cnt_reg <= '0;
      end else if (drive_cnt_reg != '1) begin
        drive_cnt_reg <= drive_cnt_reg + HOLD_ONE;
      end
      mismatch_reg <= (state_reg == DRIVE) && (drive_cnt_reg >= HOLD_LAST) &&
                      (o_top_filt != pad_o_reg);
    end
  end

  assign bus.PAD_MISMATCH = mismatch_reg;
`else
  assign filter_en = (state_reg == HIZ) || (state_reg == ON_WAIT);
`endif

  io_pad_glitch_filter #(
    .FILTER_LEN (FILTER_LEN),
    .CNT_W      (CNT_W)
  ) u_filter (
    .UserCLK (UserCLK),
    .Reset   (Reset),
    .en      (filter_en),
    .d       (bus.PAD_I),
    .q       (o_top_filt)
  );

  assign bus.O_top     = o_top_filt;
  assign bus.PAD_O     = pad_o_reg;
  assign bus.PAD_OE    = pad_oe_reg;
  assign bus.TURN_BUSY = turn_busy_reg;

endmodule
